// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Included by ifetch_unit and ifetch_holdbuf.
package ifetch_pkg;

    typedef enum logic [2:0] {
        RUN,
        WAIT,
        SQUASH,
        HOLD,
        HALTED
    } state_e;

    localparam logic [15:0] NOP_INSTR  = 16'h0800;
    localparam logic [15:0] HALT_INSTR = 16'h0000;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam logic [15:0] PC_STEP    = 16'd2;

endpackage

// File: rtl/ifetch_holdbuf.sv
// One-entry capture/hold register feeding the IF/ID boundary,
// plus a parked slot for data that arrives while decode is stalled.
module ifetch_holdbuf
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic        park,
    input  logic        rel,
    input  logic        hold,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    output logic        valid,
    output logic [15:0] park_instr
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [15:0] pk_instr_q, pk_instr_d;
    logic [15:0] pk_pc_q, pk_pc_d;

    // Select what the decode side sees next cycle.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        pk_instr_d = pk_instr_q;
        pk_pc_d    = pk_pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = in_instr;
            pc_d    = in_pc;
            valid_d = 1'b1;
        end else if (rel) begin
            instr_d = pk_instr_q;
            pc_d    = pk_pc_q;
            valid_d = 1'b1;
        end else if (!hold) begin
            valid_d = 1'b0;
        end
        if (park) begin
            pk_instr_d = in_instr;
            pk_pc_d    = in_pc;
        end
    end

    // Register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            pk_instr_q <= NOP_INSTR;
            pk_pc_q    <= RESET_PC;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            pk_instr_q <= pk_instr_d;
            pk_pc_q    <= pk_pc_d;
        end
    end

    assign instr      = valid_q ? instr_q : NOP_INSTR;
    assign pc         = pc_q;
    assign pc_inc     = pc_q + PC_STEP;
    assign valid      = valid_q;
    assign park_instr = pk_instr_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch FSM and PC logic.
// Optional sticky error tracking is enabled with IFETCH_ERR_EN.
module ifetch_unit
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_in,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        imem_stall,
    input  logic        imem_err,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic        valid,
    output logic        halt_out,
    output logic        err
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] tgt_q, tgt_d;
    logic        hsrc_q, hsrc_d;
    logic        drain_q, drain_d;
    logic        req, load, park, rel;
    logic        err_set, err_ack;
    logic [15:0] rpc, park_instr;

`ifdef IFETCH_ERR_EN
    logic err_q, err_d;
    assign rpc     = redirect_pc;
    assign err_set = imem_err | (redirect & redirect_pc[0]);
    assign err_ack = imem_err;
    // Sticky error flag; only reset clears it.
    always_comb err_d = err_q | err_set;
    // Error flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = imem_err ^ redirect_pc[0];
    assign rpc        = {redirect_pc[15:1], 1'b0};
    assign err_set    = 1'b0;
    assign err_ack    = 1'b0;
    assign err        = 1'b0;
`endif

    // Next-state, PC and capture control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        hsrc_d  = hsrc_q;
        drain_d = 1'b0;
        req     = 1'b0;
        load    = 1'b0;
        park    = 1'b0;
        rel     = 1'b0;
        unique case (state_q)
            RUN: begin
                req = !stall_in && !redirect && !halt_in;
                if (redirect) begin
                    pc_d = rpc;
                end else if (req && imem_done) begin
                    load = 1'b1;
                    pc_d = pc_q + PC_STEP;
                    if (imem_rdata == HALT_INSTR) begin
                        state_d = HALTED;
                        hsrc_d  = 1'b1;
                    end
                end else if (req && imem_stall) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (redirect) begin
                    tgt_d = rpc;
                    if (imem_done) begin
                        pc_d    = rpc;
                        state_d = RUN;
                    end else begin
                        state_d = SQUASH;
                    end
                end else if (imem_done) begin
                    pc_d = pc_q + PC_STEP;
                    if (stall_in) begin
                        park    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        load = 1'b1;
                        if (imem_rdata == HALT_INSTR) begin
                            state_d = HALTED;
                            hsrc_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            SQUASH: begin
                req = 1'b1;
                if (redirect) tgt_d = rpc;
                if (imem_done) begin
                    pc_d    = redirect ? rpc : tgt_q;
                    state_d = RUN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = rpc;
                    state_d = RUN;
                end else if (!stall_in) begin
                    rel = 1'b1;
                    if (park_instr == HALT_INSTR) begin
                        state_d = HALTED;
                        hsrc_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            HALTED: begin
                req     = drain_q;
                drain_d = drain_q && !imem_done;
                if (redirect && hsrc_q && !drain_q) begin
                    pc_d    = rpc;
                    state_d = RUN;
                    hsrc_d  = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
        if (halt_in || err_set) begin
            state_d = HALTED;
            hsrc_d  = 1'b0;
            drain_d = req && !imem_done && !err_ack;
            load    = 1'b0;
            park    = 1'b0;
            rel     = 1'b0;
        end
    end

    // FSM and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            hsrc_q  <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            hsrc_q  <= hsrc_d;
            drain_q <= drain_d;
        end
    end

    ifetch_holdbuf u_holdbuf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .load       (load),
        .park       (park),
        .rel        (rel),
        .hold       (stall_in),
        .in_instr   (imem_rdata),
        .in_pc      (pc_q),
        .instr      (instr),
        .pc         (pc),
        .pc_inc     (pc_inc),
        .valid      (valid),
        .park_instr (park_instr)
    );

    assign imem_req  = req & rst;
    assign imem_addr = pc_q;
    assign rs        = instr[10:8];
    assign rt        = instr[7:5];
    assign halt_out  = valid && (instr == HALT_INSTR);

endmodule
